// File: rtl/wave_pkg.sv
// Shared constants for the function-generator datapath: table geometry, default
// sample divider, and the gear encodings with their phase-step values.
package wave_pkg;

  localparam int unsigned ADDR_W          = 8;
  localparam int unsigned STEP_W          = 8;
  localparam int unsigned CLK_DIV_DEFAULT = 2000;

  typedef enum logic [1:0] {
    GEAR_X10 = 2'b11,
    GEAR_X4  = 2'b01,
    GEAR_X2  = 2'b00,
    GEAR_X1  = 2'b10
  } gear_e;

  localparam logic [STEP_W-1:0] STEP_X10 = STEP_W'(10);
  localparam logic [STEP_W-1:0] STEP_X4  = STEP_W'(4);
  localparam logic [STEP_W-1:0] STEP_X2  = STEP_W'(2);
  localparam logic [STEP_W-1:0] STEP_X1  = STEP_W'(1);

  function automatic logic [STEP_W-1:0] gear_to_step(input gear_e gear);
    logic [STEP_W-1:0] step;
    step = STEP_X1;
    unique case (gear)
      GEAR_X10: step = STEP_X10;
      GEAR_X4:  step = STEP_X4;
      GEAR_X2:  step = STEP_X2;
      GEAR_X1:  step = STEP_X1;
      default:  step = STEP_X1;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Sample-rate divider: counts 0..CLK_DIV-1 while enabled, held at 0 otherwise,
// and flags the terminal count as a one-cycle tick.
module tick_divider #(
  parameter int unsigned CLK_DIV = 2000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign tick   = en && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!en) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wave_addr_gen.sv
// Waveform-table address generator: phase accumulator advanced on each sample tick,
// step latched only at period wrap. Optional macro WAVE_ADDR_GEN_PHASE_OFS_EN adds phase_ofs.
module wave_addr_gen #(
  parameter int unsigned CLK_DIV = wave_pkg::CLK_DIV_DEFAULT,
  parameter int unsigned ADDR_W  = wave_pkg::ADDR_W,
  parameter int unsigned STEP_W  = wave_pkg::STEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [STEP_W-1:0] f_step,
`ifdef WAVE_ADDR_GEN_PHASE_OFS_EN
  input  logic [ADDR_W-1:0] phase_ofs,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              cycle_start
);

  import wave_pkg::*;

  logic              w_tick;
  logic [ADDR_W:0]   w_sum;
  logic              w_carry;
  logic [STEP_W-1:0] w_step_in;
  logic [ADDR_W-1:0] w_addr_next;

  logic [ADDR_W-1:0] r_phase;
  logic [STEP_W-1:0] r_step_q;
  logic [ADDR_W-1:0] r_addr;
  logic              r_addr_valid;
  logic              r_cycle_start;

  tick_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (w_tick)
  );

  // A zero step would freeze the accumulator, so it is promoted to 1 on capture.
  assign w_step_in = (f_step == '0) ? STEP_W'(1) : f_step;

  assign w_sum   = {1'b0, r_phase} + (ADDR_W + 1)'(r_step_q);
  assign w_carry = w_sum[ADDR_W];

`ifdef WAVE_ADDR_GEN_PHASE_OFS_EN
  assign w_addr_next = w_sum[ADDR_W-1:0] + phase_ofs;
`else
  assign w_addr_next = w_sum[ADDR_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase       <= '0;
      r_addr        <= '0;
      r_addr_valid  <= 1'b0;
      r_cycle_start <= 1'b0;
    end else begin
      r_addr_valid  <= w_tick;
      r_cycle_start <= w_tick && w_carry;
      if (w_tick) begin
        r_phase <= w_sum[ADDR_W-1:0];
        r_addr  <= w_addr_next;
      end
    end
  end

  // Step tracks the input freely while idle, otherwise only at a period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_q <= STEP_W'(1);
    end else if (!en || (w_tick && w_carry)) begin
      r_step_q <= w_step_in;
    end
  end

  assign addr        = r_addr;
  assign addr_valid  = r_addr_valid;
  assign cycle_start = r_cycle_start;

endmodule

// File: doc/wave_addr_gen.md
# wave_addr_gen

Sample-address generator for the function generator datapath. It consumes the frequency step word produced by the gear-to-step decoder and divides the 50 MHz system clock down to the sample rate. At each sample tick it advances an 8-bit phase accumulator across the 256-point waveform table and emits the table read address with a one-cycle valid strobe. Step changes take effect only at a waveform period boundary, so gear switching never produces a phase discontinuity mid-period.

## Interface
Parameters:
- CLK_DIV, 2000: system clocks per sample tick (50 MHz / 2000 = 40 us); legal range ≥ 2.
- ADDR_W, 8: phase/address width (256-point table).
- STEP_W, 8: width of the step input.

Ports:
- clk  in  1  system clock, 50 MHz. One clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  run enable.
- f_step  in  STEP_W  phase increment per tick, from the gear decoder.
- addr  out  ADDR_W  waveform table read address (registered).
- addr_valid  out  1  one-cycle strobe; addr holds a new sample address this cycle.
- cycle_start  out  1  one-cycle strobe, coincident with addr_valid, when the accumulator wrapped on this update.

## Operation
- Reset values: div_cnt=0, phase=0, step_q=1, addr=0, addr_valid=0, cycle_start=0.
- Divider: while en=1, div_cnt counts 0..CLK_DIV-1 and wraps. tick = en && div_cnt==CLK_DIV-1.
- Accumulator: on tick, sum = phase + step_q at ADDR_W+1 bits. Then phase ← sum[ADDR_W-1:0], which is also driven on addr, and addr_valid ← 1. cycle_start ← sum[ADDR_W], the carry bit.
- Step latch: step_q loads f_step on a tick that produces a carry. It also loads continuously while en=0. The new step applies from the next tick. A latched value of 0 is replaced by 1, so the generator never stalls.
- en=0: div_cnt is forced to 0. phase and addr hold. No strobes.
- en 0→1: the first tick occurs CLK_DIV cycles later. The first update is phase + step_q. Phase is not reset by en.
- f_step changes mid-period: they are ignored until the next wrap.
- Output waveform frequency = f_clk / (CLK_DIV·2^ADDR_W) · step. When 256 is not a multiple of step, the wrap remainder carries into the next period; phase is not zeroed.

## Timing
- Strobe latency: addr/addr_valid/cycle_start update on the clock edge where tick=1 and are valid for exactly that following cycle. Strobe period = CLK_DIV cycles.
- The table ROM samples addr when addr_valid=1. There is no backpressure; the consumer must accept every strobe.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). After release, the first tick comes CLK_DIV cycles later if en=1.
- Simultaneous wrap and f_step change on the same edge: the value of f_step present at that edge is captured.

## Configuration
- WAVE_ADDR_GEN_PHASE_OFS_EN defined: this adds input phase_ofs [ADDR_W-1:0]. addr = phase + phase_ofs (mod 2^ADDR_W), and is registered on the same tick edge. phase_ofs is sampled only on ticks. cycle_start still follows the raw accumulator carry, not the offset address.
- Undefined: there is no phase_ofs port, and addr = phase.

## Structure
- Shared package wave_pkg holds:
  - ADDR_W, STEP_W, and CLK_DIV_DEFAULT (2000);
  - the gear encodings 2'b11/01/00/10 and their step constants 10/4/2/1, also used by the decoder.
- One sub-module: tick_divider (parameter CLK_DIV; ports clk, rst_n, en, tick). The accumulator and step latch stay in wave_addr_gen.

## Test plan
Run the bench with CLK_DIV=4 for speed.
- Reset release, en=1, f_step=1 → addr_valid every 4 cycles, addr 1,2,…,255,0. cycle_start fires only on the 0 update, with 256 strobes between pulses.
- f_step=10 → addr 10,20,…,250,4 (cycle_start=1),14,… Confirm the remainder carries across the wrap.
- Switch f_step 1→4 when addr=100 → steps of 1 continue to 255→0. Steps of 4 begin after the wrap: 4,8,… No earlier change.
- f_step=0 held through en=0 then en=1 → behaves as step 1; addr advances 1 per strobe.
- en dropped at addr=37 for 50 cycles → no strobes and addr stays 37. After re-enable, the first strobe comes exactly 4 cycles later with addr=38.
- rst_n pulsed low mid-period at addr=200 → outputs are 0 immediately and step_q=1. The first post-reset strobe gives addr=1.
